// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: CPU stores to TXDATA queue bytes that are sent as 8N1 frames.
// Define MMIO_UART_TX_PARITY_EN to append an even-parity bit to every frame.
module mmio_uart_tx #(
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  w_en,
  input  logic [15:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        tx_busy,
  output logic        fifo_full
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

`ifdef MMIO_UART_TX_PARITY_EN
  localparam state_e AFTER_DATA = S_PARITY;
  localparam logic   PAR_FLAG   = 1'b1;
`else
  localparam state_e AFTER_DATA = S_STOP;
  localparam logic   PAR_FLAG   = 1'b0;
`endif

  logic          hit;
  logic [3:0]    off;
  logic          push_req, push_ok, pop, ovf_clr, div_wr, load;
  logic          fifo_empty, tick;
  logic [15:0]   div_eff;
  logic [4:0]    cnt5;
  logic          unused_bits;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   div_q, div_d;
  state_e        state_q, state_d;
  logic [15:0]   timer_q, timer_d, cur_div_q, cur_div_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;

  assign hit         = (address[15:4] == BASE_ADDR[15:4]);
  assign off         = address[3:0];
  assign push_req    = hit && (off == 4'h0) && w_en[0];
  assign push_ok     = push_req && (count_q < DEPTH_C);
  assign ovf_clr     = hit && (off == 4'h4) && w_en[0] && write_data[3];
  assign div_wr      = hit && (off == 4'h8) && (w_en[1:0] == 2'b11);
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == DEPTH_C);
  assign tick        = (timer_q == '0);
  assign div_eff     = (div_q == '0) ? 16'd1 : div_q;
  assign cnt5        = 5'(count_q);
  assign tx          = tx_q;
  assign tx_busy     = (state_q != S_IDLE);
  assign unused_bits = ^{write_data[31:16], w_en[3:2]};

  always_comb begin
    read_data = '0;
    if (hit) begin
      case (off)
        4'h4:    read_data = {18'b0, cnt5, 4'b0, PAR_FLAG, ovf_q, tx_busy, fifo_empty, fifo_full};
        4'h8:    read_data = {16'b0, div_q};
        default: read_data = '0;
      endcase
    end
  end

  // Push acceptance uses the pre-edge count, so a push while full is dropped even if a pop occurs.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    div_d   = div_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop)     rptr_d = rptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (ovf_clr)              ovf_d = 1'b0;
    if (push_req && !push_ok) ovf_d = 1'b1;
    if (div_wr)               div_d = write_data[15:0];
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = tick ? (cur_div_q - 16'd1) : (timer_q - 16'd1);
    cur_div_d = cur_div_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    pop       = 1'b0;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = timer_q;
        if (!fifo_empty) load = 1'b1;
      end
      S_START: if (tick) begin
        state_d = S_DATA;
        idx_d   = '0;
      end
      S_DATA: if (tick) begin
        shift_d = {1'b0, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = AFTER_DATA;
      end
      S_PARITY: if (tick) state_d = S_STOP;
      S_STOP: if (tick) begin
        if (!fifo_empty) load = 1'b1;
        else             state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Frame start: pop, latch divisor, and enter START so tx drops on this same edge.
    if (load) begin
      pop       = 1'b1;
      shift_d   = mem_q[rptr_q];
      par_d     = ^mem_q[rptr_q];
      cur_div_d = div_eff;
      timer_d   = div_eff - 16'd1;
      state_d   = S_START;
    end
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= write_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      div_q     <= DEFAULT_DIV;
      state_q   <= S_IDLE;
      timer_q   <= '0;
      cur_div_q <= 16'd1;
      idx_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      div_q     <= div_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      cur_div_q <= cur_div_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: serial frames are decoded and matched against a byte scoreboard.
module tb_mmio_uart_tx;

`ifdef MMIO_UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [31:0] PB = 32'h10;
`else
  localparam int NB = 10;
  localparam logic [31:0] PB = 32'h0;
`endif

  logic        clk, rst, tx, tx_busy, fifo_full;
  logic [3:0]  w_en;
  logic [15:0] address;
  logic [31:0] write_data, read_data;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];
  int rx_div = 1;
  bit rx_en = 1'b1;

  mmio_uart_tx #(.BASE_ADDR(16'hFF00), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd868)) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .address(address), .write_data(write_data),
    .read_data(read_data), .tx(tx), .tx_busy(tx_busy), .fifo_full(fifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a; write_data = d; w_en = be;
    @(negedge clk);
    w_en = 4'h0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp, input string tag);
    address = a; w_en = 4'h0;
    #1;
    check(tag, read_data, exp);
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (tx_busy === 1'b1 && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Serial receiver: samples mid-bit, checks framing, and pops the scoreboard on each stop bit.
  initial begin
    int pos, bitn;
    bit act;
    logic [7:0] rx_byte, e;
    act = 0; pos = 0; rx_byte = '0;
    forever begin
      @(negedge clk);
      if (!rx_en || rst) act = 0;
      else begin
        if (!act) begin
          if (tx === 1'b0) begin act = 1; pos = 0; end
        end else pos++;
        if (act) begin
          bitn = pos / rx_div;
          if (pos % rx_div == rx_div / 2) begin
            if (bitn == 0) check("rx_start_bit", tx, 1'b0);
            else if (bitn <= 8) rx_byte[bitn-1] = tx;
            else if (bitn == NB - 1) begin
              check("rx_stop_bit", tx, 1'b1);
              if (sb.size() == 0) begin
                checks++; failures++;
                $error("FAIL rx_frame observed=%h expected=no_frame", rx_byte);
              end else begin
                e = sb.pop_front();
                check("rx_byte", rx_byte, e);
              end
            end else check("rx_parity_bit", tx, ^rx_byte);
          end
          if (pos == NB * rx_div - 1) act = 0;
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; w_en = 4'h0; address = 16'h0; write_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("reset_tx", tx, 1'b1);
    check("reset_busy", tx_busy, 1'b0);
    check("reset_full", fifo_full, 1'b0);
    rd(16'hFF04, 32'h2 | PB, "reset_status");
    rd(16'hFF08, 32'h364, "reset_baud");

    // Single frame, div=4
    wr(16'hFF08, 32'd4, 4'b0011);
    rx_div = 4;
    sb.push_back(8'hA5);
    wr(16'hFF00, 32'hA5, 4'b0001);
    check("a5_tx_before_pop", tx, 1'b1);
    @(negedge clk);
    check("a5_tx_falls", tx, 1'b0);
    check("a5_busy", tx_busy, 1'b1);
    wait_idle(200, n);
    check("a5_busy_cycles", n, NB * 4);
    check("a5_sb_drained", sb.size(), 0);

    // Back-to-back frames, div=2
    wr(16'hFF08, 32'd2, 4'b0011);
    rx_div = 2;
    sb.push_back(8'h01); sb.push_back(8'h02); sb.push_back(8'h03);
    wr(16'hFF00, 32'h01, 4'b0001);
    wr(16'hFF00, 32'h02, 4'b0001);
    wr(16'hFF00, 32'h03, 4'b0001);
    rd(16'hFF04, (32'd2 << 9) | 32'h4 | PB, "b2b_status_queued");
    n = 2;
    while (tx_busy === 1'b1 && n < 400) begin
      if (n == 2 * NB)     check("b2b_count_before_2nd", read_data[13:9], 2);
      if (n == 2 * NB + 1) check("b2b_count_2nd_start", read_data[13:9], 1);
      if (n == 4 * NB + 1) check("b2b_count_3rd_start", read_data[13:9], 0);
      n++;
      @(negedge clk);
    end
    check("b2b_busy_cycles", n - 1, 6 * NB);
    check("b2b_sb_drained", sb.size(), 0);

    // Overflow, div=100
    wr(16'hFF08, 32'd100, 4'b0011);
    rx_div = 100;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) sb.push_back(8'(8'h10 + i));
      wr(16'hFF00, 32'(8'h10 + i), 4'b0001);
    end
    check("ovf_full", fifo_full, 1'b1);
    rd(16'hFF04, 32'h100D | PB, "ovf_status_set");
    wr(16'hFF04, 32'h8, 4'b0001);
    rd(16'hFF04, 32'h1005 | PB, "ovf_status_cleared");
    wait_idle(15000, n);
    check("ovf_idle", tx_busy, 1'b0);
    check("ovf_not_full", fifo_full, 1'b0);
    check("ovf_sb_drained", sb.size(), 0);

    // Divisor 0 behaves as 1
    wr(16'hFF08, 32'd0, 4'b0011);
    rd(16'hFF08, 32'h0, "div0_readback");
    rx_div = 1;
    sb.push_back(8'hFF);
    wr(16'hFF00, 32'hFF, 4'b0001);
    @(negedge clk);
    check("div0_tx_start", tx, 1'b0);
    wait_idle(100, n);
    check("div0_busy_cycles", n, NB);
    check("div0_sb_drained", sb.size(), 0);

    // Reset in the middle of a frame
    rx_en = 1'b0;
    wr(16'hFF00, 32'h3C, 4'b0001);
    @(negedge clk);
    check("midrst_tx_start", tx, 1'b0);
    repeat (4) @(negedge clk);
    check("midrst_busy_before", tx_busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", tx_busy, 1'b0);
    rd(16'hFF04, 32'h2 | PB, "midrst_status");
    rd(16'hFF08, 32'h364, "midrst_baud");
    rx_en = 1'b1;

    // Address decode
    wr(16'hFF10, 32'hFFFF_FF55, 4'hF);
    wr(16'hFF0C, 32'hFFFF_FFFF, 4'hF);
    rd(16'hFF04, 32'h2 | PB, "decode_no_push");
    @(negedge clk);
    check("decode_tx_idle", tx, 1'b1);
    check("decode_busy_idle", tx_busy, 1'b0);
    rd(16'h1004, 32'h0, "decode_miss_status");
    rd(16'h1008, 32'h0, "decode_miss_baud");
    rd(16'hFF0C, 32'h0, "decode_reserved");
    rd(16'hFF08, 32'h364, "decode_baud_untouched");

    // Byte with odd popcount (parity bit 1 when enabled)
    wr(16'hFF08, 32'd3, 4'b0011);
    rx_div = 3;
    sb.push_back(8'h07);
    wr(16'hFF00, 32'h07, 4'b0001);
    @(negedge clk);
    wait_idle(200, n);
    check("b07_busy_cycles", n, NB * 3);
    check("b07_sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
